// File: rtl/lfsr_sched_pkg.sv
// Shared constants and types for the LFSR burst scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: pixel width, default burst-length width, FSM state type,
// the seed used in place of an all-zero seed, and the LFSR next-state function.
package lfsr_sched_pkg;

  localparam int MAX_PIXEL_BITS = 8;
  localparam int LEN_BITS_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // An all-zero LFSR never leaves zero, so a zero seed is replaced by this.
  localparam logic [MAX_PIXEL_BITS-1:0] ZERO_SEED_SUB = MAX_PIXEL_BITS'(1);

  // Right shift; the new MSB is the XOR of taps 0, 2, 3 and 5.
  function automatic logic [MAX_PIXEL_BITS-1:0] lfsr_next(
    input logic [MAX_PIXEL_BITS-1:0] s
  );
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[MAX_PIXEL_BITS-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Pixel LFSR register with synchronous load and step enable.
// Latency: state updates one cycle after load/step is sampled.
// Backpressure: none; the caller gates step with its handshake.
//
// Ports: clk_i, nreset_i (async, active-high), load + seed (zero seed is
// substituted), step (advance one position), state (current register).
module lfsr_step
  import lfsr_sched_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      load,
  input  logic [MAX_PIXEL_BITS-1:0] seed,
  input  logic                      step,
  output logic [MAX_PIXEL_BITS-1:0] state
);

  always_ff @(posedge clk_i or posedge nreset_i) begin
    if (nreset_i) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == '0) ? ZERO_SEED_SUB : seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/lfsr_sched.sv
// Arbitrates NUM_REQ burst requesters and streams a pseudo-random pixel burst for the winner.
// Latency: grant 1 cycle after request, first beat 2 cycles after request, done 1 cycle after last beat.
// Backpressure: pix_ready_i low holds pix_o and the beat count; dropping the granted request aborts.
//
// Ports: clk_i, nreset_i (async active-high), req_i/seed_i/len_i per requester,
// gnt_o (one-hot), pix_o/pix_valid_o/pix_ready_i (beat handshake), done_o, busy_o.
// Build option: define LFSR_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration;
// by default arbitration is round-robin starting from the requester after the last winner.
module lfsr_sched
  import lfsr_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int LEN_BITS = LEN_BITS_DEF
) (
  input  logic                               clk_i,
  input  logic                               nreset_i,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ*MAX_PIXEL_BITS-1:0]  seed_i,
  input  logic [NUM_REQ*LEN_BITS-1:0]        len_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  output logic [MAX_PIXEL_BITS-1:0]          pix_o,
  output logic                               pix_valid_o,
  input  logic                               pix_ready_i,
  output logic [NUM_REQ-1:0]                 done_o,
  output logic                               busy_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                    state_q;
  logic [NUM_REQ-1:0]        gnt_q;
  logic [MAX_PIXEL_BITS-1:0] seed_q;
  logic [MAX_PIXEL_BITS-1:0] seed_sel;
  logic [LEN_BITS-1:0]       len_q;
  logic [LEN_BITS-1:0]       len_sel;
  logic [LEN_BITS-1:0]       cnt_q;
  logic [LEN_BITS-1:0]       cnt_nxt;
  logic [PTR_W-1:0]          win_idx;
  logic                      win_found;
  logic                      req_held;
  logic                      abort;
  logic                      beat_acc;
  logic [MAX_PIXEL_BITS-1:0] lfsr_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef LFSR_SCHED_FIXED_PRIO_EN
  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] win_q;
  logic [PTR_W-1:0] cand;

  // First set request at or after rr_ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(rr_ptr_q) + i >= NUM_REQ) begin
        cand = PTR_W'(int'(rr_ptr_q) + i - NUM_REQ);
      end else begin
        cand = PTR_W'(int'(rr_ptr_q) + i);
      end
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pointer moves past the winner whether the burst completes or aborts.
  always_ff @(posedge clk_i or posedge nreset_i) begin
    if (nreset_i) begin
      rr_ptr_q <= '0;
      win_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && win_found) begin
        win_q <= win_idx;
      end
      if (state_q == ST_DONE || abort) begin
        rr_ptr_q <= (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
      end
    end
  end
`endif

  // Winner's seed and length, captured only at grant time so later input
  // changes cannot disturb the running burst.
  always_comb begin
    seed_sel = '0;
    len_sel  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == PTR_W'(k)) begin
        seed_sel = seed_i[k*MAX_PIXEL_BITS +: MAX_PIXEL_BITS];
        len_sel  = len_i[k*LEN_BITS +: LEN_BITS];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and abort
  // ---------------------------------------------------------------------------
  assign req_held    = |(req_i & gnt_q);
  assign abort       = (state_q == ST_LOAD || state_q == ST_RUN) && !req_held;
  // Valid drops in the same cycle the granted request falls.
  assign pix_valid_o = (state_q == ST_RUN) && req_held;
  assign beat_acc    = pix_valid_o && pix_ready_i;
  assign cnt_nxt     = cnt_q + LEN_BITS'(1);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge nreset_i) begin
    if (nreset_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      seed_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            gnt_q   <= NUM_REQ'(1) << win_idx;
            seed_q  <= seed_sel;
            len_q   <= len_sel;
            cnt_q   <= '0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            gnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (len_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            gnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (beat_acc) begin
            cnt_q <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  lfsr_step u_lfsr_step (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .load     (state_q == ST_LOAD),
    .seed     (seed_q),
    .step     (beat_acc),
    .state    (lfsr_q)
  );

  assign pix_o  = lfsr_q;
  assign gnt_o  = gnt_q;
  assign done_o = (state_q == ST_DONE) ? gnt_q : '0;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lfsr_sched.sv
// Directed bench for lfsr_sched with NUM_REQ=4, 8-bit pixels and lengths.
// Inputs are driven and outputs sampled on the falling clock edge.
// Grant expectations follow LFSR_SCHED_FIXED_PRIO_EN when it is defined.
module tb_lfsr_sched;

  logic        clk = 1'b0;
  logic        nreset_i;
  logic [3:0]  req_i;
  logic [31:0] seed_i;
  logic [31:0] len_i;
  logic [3:0]  gnt_o;
  logic [7:0]  pix_o;
  logic        pix_valid_o;
  logic        pix_ready_i;
  logic [3:0]  done_o;
  logic        busy_o;

  int total   = 0;
  int bad     = 0;
  int acc_cnt = 0;
  int base;

  always #5 clk = ~clk;

  lfsr_sched #(
    .NUM_REQ  (4),
    .LEN_BITS (8)
  ) dut (
    .clk_i       (clk),
    .nreset_i    (nreset_i),
    .req_i       (req_i),
    .seed_i      (seed_i),
    .len_i       (len_i),
    .gnt_o       (gnt_o),
    .pix_o       (pix_o),
    .pix_valid_o (pix_valid_o),
    .pix_ready_i (pix_ready_i),
    .done_o      (done_o),
    .busy_o      (busy_o)
  );

  // Independent tally of accepted beats.
  always @(posedge clk) begin
    if (pix_valid_o && pix_ready_i) acc_cnt <= acc_cnt + 1;
  end

`ifdef LFSR_SCHED_FIXED_PRIO_EN
  localparam logic [3:0] EXP_T5 = 4'b0001;
`else
  localparam logic [3:0] EXP_T5 = 4'b0100;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_gnt"},  {28'b0, gnt_o}, 32'h0);
    chk({tag, "_vld"},  {31'b0, pix_valid_o}, 32'h0);
    chk({tag, "_done"}, {28'b0, done_o}, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'h0);
  endtask

  task automatic wait_gnt(input string tag, output logic [3:0] g);
    int n;
    n = 0;
    while (gnt_o == 4'b0 && n < 20) begin
      step();
      n++;
    end
    g = gnt_o;
    chk({tag, "_seen"}, {31'b0, (gnt_o != 4'b0)}, 32'h1);
  endtask

  task automatic wait_done(input string tag, input logic [3:0] g);
    int n;
    n = 0;
    while (done_o == 4'b0 && n < 20) begin
      step();
      n++;
    end
    chk(tag, {28'b0, done_o}, {28'b0, g});
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] exp_order [4];
`ifdef LFSR_SCHED_FIXED_PRIO_EN
    exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_order = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
`endif
    nreset_i    = 1'b1;
    req_i       = '0;
    seed_i      = '0;
    len_i       = '0;
    pix_ready_i = 1'b1;

    // Reset state
    repeat (3) step();
    check_idle("reset");
    chk("reset_pix", {24'b0, pix_o}, 32'h0);
    nreset_i = 1'b0;
    step();
    check_idle("no_req");

    // Requester 0, seed 01, length 4, ready high
    seed_i[7:0] = 8'h01;
    len_i[7:0]  = 8'd4;
    req_i       = 4'b0001;
    step();
    chk("t1_load_gnt",  {28'b0, gnt_o}, 32'h1);
    chk("t1_load_vld",  {31'b0, pix_valid_o}, 32'h0);
    chk("t1_load_busy", {31'b0, busy_o}, 32'h1);
    // Changing the winner's inputs mid-burst must have no effect.
    seed_i[7:0] = 8'hFF;
    len_i[7:0]  = 8'd1;
    step();
    chk("t1_b0",     {24'b0, pix_o}, 32'h01);
    chk("t1_b0_vld", {31'b0, pix_valid_o}, 32'h1);
    step();
    chk("t1_b1", {24'b0, pix_o}, 32'h80);
    step();
    chk("t1_b2", {24'b0, pix_o}, 32'h40);
    step();
    chk("t1_b3", {24'b0, pix_o}, 32'h20);
    step();
    chk("t1_done",     {28'b0, done_o}, 32'h1);
    chk("t1_done_vld", {31'b0, pix_valid_o}, 32'h0);
    chk("t1_done_gnt", {28'b0, gnt_o}, 32'h1);
    req_i = 4'b0000;
    step();
    check_idle("t1_after");

    // Requesters 0 and 2 held, length 2 each, from a fresh reset
    nreset_i = 1'b1;
    step();
    nreset_i = 1'b0;
    seed_i   = {8'h00, 8'h33, 8'h00, 8'h11};
    len_i    = {8'd0, 8'd2, 8'd0, 8'd2};
    req_i    = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      wait_gnt($sformatf("t2_gnt%0d", n), g);
      chk($sformatf("t2_order%0d", n), {28'b0, g}, {28'b0, exp_order[n]});
      wait_done($sformatf("t2_done%0d", n), g);
      if (n == 3) req_i = 4'b0000;
      step();
    end
    check_idle("t2_after");

    // Zero seed, length 2
    seed_i[7:0] = 8'h00;
    len_i[7:0]  = 8'd2;
    req_i       = 4'b0001;
    step();
    chk("t3_load_gnt", {28'b0, gnt_o}, 32'h1);
    step();
    chk("t3_b0", {24'b0, pix_o}, 32'h01);
    step();
    chk("t3_b1", {24'b0, pix_o}, 32'h80);
    step();
    chk("t3_done", {28'b0, done_o}, 32'h1);
    req_i = 4'b0000;
    step();
    check_idle("t3_after");

    // Length 0: LOAD straight to DONE, no beat
    len_i[7:0] = 8'd0;
    req_i      = 4'b0001;
    base       = acc_cnt;
    step();
    chk("t3z_load_gnt", {28'b0, gnt_o}, 32'h1);
    chk("t3z_load_vld", {31'b0, pix_valid_o}, 32'h0);
    step();
    chk("t3z_done",     {28'b0, done_o}, 32'h1);
    chk("t3z_done_vld", {31'b0, pix_valid_o}, 32'h0);
    chk("t3z_beats",    acc_cnt - base, 32'd0);
    req_i = 4'b0000;
    step();
    check_idle("t3z_after");

    // Length 3 with five stalled cycles after the first beat
    seed_i[7:0] = 8'h01;
    len_i[7:0]  = 8'd3;
    req_i       = 4'b0001;
    base        = acc_cnt;
    step();
    step();
    chk("t4_b0", {24'b0, pix_o}, 32'h01);
    pix_ready_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      chk($sformatf("t4_hold%0d", s), {24'b0, pix_o}, 32'h01);
      chk($sformatf("t4_hold_vld%0d", s), {31'b0, pix_valid_o}, 32'h1);
    end
    pix_ready_i = 1'b1;
    step();
    chk("t4_b1", {24'b0, pix_o}, 32'h80);
    step();
    chk("t4_b2", {24'b0, pix_o}, 32'h40);
    step();
    chk("t4_done",  {28'b0, done_o}, 32'h1);
    chk("t4_beats", acc_cnt - base, 32'd3);
    req_i = 4'b0000;
    step();
    check_idle("t4_after");

    // Abort: requester 1 drops during its second beat
    seed_i[15:8] = 8'h5A;
    len_i[15:8]  = 8'd4;
    req_i        = 4'b0010;
    step();
    chk("t5_load_gnt", {28'b0, gnt_o}, 32'h2);
    step();
    chk("t5_b0", {24'b0, pix_o}, 32'h5A);
    step();
    chk("t5_b1", {24'b0, pix_o}, 32'hAD);
    req_i = 4'b0101;
    #1;
    chk("t5_abort_vld",  {31'b0, pix_valid_o}, 32'h0);
    chk("t5_abort_done", {28'b0, done_o}, 32'h0);
    step();
    check_idle("t5_idle");
    step();
    chk("t5_next_gnt", {28'b0, gnt_o}, {28'b0, EXP_T5});
    wait_done("t5_next_done", EXP_T5);
    req_i = 4'b0000;
    step();
    check_idle("t5_after");

    // Asynchronous reset in the middle of a burst
    seed_i[7:0] = 8'hC3;
    len_i[7:0]  = 8'd4;
    req_i       = 4'b0001;
    step();
    step();
    chk("t6_b0", {24'b0, pix_o}, 32'hC3);
    step();
    chk("t6_b1", {24'b0, pix_o}, 32'hE1);
    #2;
    nreset_i = 1'b1;
    #1;
    check_idle("t6_async");
    chk("t6_async_pix", {24'b0, pix_o}, 32'h0);
    step();
    nreset_i = 1'b0;
    step();
    chk("t6_regrant", {28'b0, gnt_o}, 32'h1);
    step();
    chk("t6_restart_pix", {24'b0, pix_o}, 32'hC3);
    chk("t6_restart_vld", {31'b0, pix_valid_o}, 32'h1);
    req_i = 4'b0000;
    step();
    check_idle("t6_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_sched.md
LFSR_SCHED -- requirements
Module: lfsr_sched

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters (2..8); LEN_BITS, default 8, burst-length width; MAX_PIXEL_BITS, from the shared package, default 8, pixel width.
REQ-002 clk_i  in  1  single clock; all state SHALL update on posedge clk_i.
REQ-003 nreset_i  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 req_i  in  NUM_REQ  per-requester burst request, level, held until done_o.
REQ-005 seed_i  in  NUM_REQ*MAX_PIXEL_BITS  per-requester seed, slice k = requester k.
REQ-006 len_i  in  NUM_REQ*LEN_BITS  per-requester burst length in pixels.
REQ-007 gnt_o  out  NUM_REQ  one-hot grant, held from LOAD through DONE.
REQ-008 pix_o  out  MAX_PIXEL_BITS  current pseudo-random pixel.
REQ-009 pix_valid_o  out  1  pix_o valid; pix_ready_i  in  1  consumer accepts beat.
REQ-010 done_o  out  NUM_REQ  one-cycle pulse on the granted requester's bit after its last beat.
REQ-011 busy_o  out  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, RUN, DONE; one state per cycle except RUN.
REQ-013 IDLE: if any req_i bit is set, select the winner (REQ-014), latch its seed and length, set gnt_o, go to LOAD; otherwise stay in IDLE.
REQ-014 Round-robin: the winner is the first set req_i bit at or after rr_ptr, modulo NUM_REQ; rr_ptr resets to 0.
REQ-015 LOAD: load the LFSR register with the latched seed, or 8'h01 (LSB set) if the seed is zero to prevent lockup; go to RUN, or to DONE if the length is 0.
REQ-016 RUN: pix_valid_o=1 and pix_o=LFSR register; the first beat is the loaded seed.
REQ-017 On pix_valid_o&&pix_ready_i, the LFSR SHALL step to {s[0]^s[2]^s[3]^s[5], s[MAX_PIXEL_BITS-1:1]} and the beat counter SHALL increment; with pix_ready_i low, pix_o and the counter SHALL hold.
REQ-018 When the beat completing count==length is accepted, go to DONE.
REQ-019 DONE: pulse done_o[winner] for one cycle, set rr_ptr=winner+1 (mod NUM_REQ), clear gnt_o, return to IDLE; a new grant starts at the earliest on the next cycle.
REQ-020 Abort: if req_i[winner] falls in LOAD or RUN, go directly to IDLE next cycle with no done_o pulse; rr_ptr SHALL advance as in DONE; pix_valid_o SHALL drop that cycle.
REQ-021 Changes to req_i, seed_i or len_i of any requester SHALL not affect a burst in progress, except for abort (REQ-020).
REQ-022 pix_valid_o SHALL be 0 outside RUN; gnt_o SHALL always be one-hot or zero.

Reset
REQ-023 Asserting nreset_i in any state SHALL immediately force IDLE, gnt_o=0, pix_valid_o=0, done_o=0, busy_o=0, pix_o=0, counter=0, rr_ptr=0; a burst in progress is discarded.
REQ-024 After nreset_i deasserts, the first grant SHALL occur no earlier than the first posedge with req_i nonzero.

Configuration
REQ-025 LFSR_SCHED_FIXED_PRIO_EN defined: the winner SHALL be the lowest set req_i index, and rr_ptr is unused. Undefined: round-robin per REQ-014.

Structure
REQ-026 MAX_PIXEL_BITS, the LEN_BITS default, the FSM state enum typedef and the zero-seed substitute constant SHALL live in the shared parameters package.
REQ-027 The shift register with step enable SHALL be one sub-module, lfsr_step, with inputs load, seed, step and output state; arbitration and the FSM stay in lfsr_sched.

Verification
REQ-028 Requester 0, seed 8'h01, length 4, ready held high -> pix_o 01,80,40,20 on consecutive cycles, then done_o[0] pulse, busy_o low next cycle.
REQ-029 Requesters 0 and 2 both held, length 2 each -> grant order 0,2,0,2; with the macro defined -> grant order 0,0,0.
REQ-030 Seed 8'h00, length 2 -> pix_o 01 then 80; length 0 -> LOAD→DONE with done_o pulse and no valid beat.
REQ-031 Length 3, pix_ready_i low for 5 cycles after the first beat -> pix_o held at 01, then 80,40, with exactly 3 accepted beats.
REQ-032 req_i[1] dropped during the second RUN beat -> IDLE next cycle, no done_o, next grant goes to the requester after 1.
REQ-033 nreset_i asserted mid-RUN, asynchronously -> all outputs zero before the next clock edge; a fresh request after release restarts from the seed.
